// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the execute-stage ALU: opcode values, mul/div FSM
// states and the opcode classifier used by the top.
package alu_pkg;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t ALU_AND   = 5'd0;
  localparam alu_op_t ALU_OR    = 5'd1;
  localparam alu_op_t ALU_ADD   = 5'd2;
  localparam alu_op_t ALU_SUB   = 5'd3;
  localparam alu_op_t ALU_SLT   = 5'd4;
  localparam alu_op_t ALU_SLTU  = 5'd5;
  localparam alu_op_t ALU_XOR   = 5'd6;
  localparam alu_op_t ALU_NOR   = 5'd7;
  localparam alu_op_t ALU_SLL   = 5'd8;
  localparam alu_op_t ALU_SRL   = 5'd9;
  localparam alu_op_t ALU_SRA   = 5'd10;
  localparam alu_op_t ALU_MULT  = 5'd11;
  localparam alu_op_t ALU_MULTU = 5'd12;
  localparam alu_op_t ALU_DIV   = 5'd13;
  localparam alu_op_t ALU_DIVU  = 5'd14;
  localparam alu_op_t ALU_MFHI  = 5'd15;
  localparam alu_op_t ALU_MFLO  = 5'd16;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_ITER = 2'd1,
    MD_FIN  = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input alu_op_t op);
    return (op >= ALU_MULT) && (op <= ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the register-read stage and the ALU.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
) ();
  import alu_pkg::*;

  logic             Start;
  alu_op_t          ALUSec;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] ALU_result;
  logic             Zero;
  logic             Overflow;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, ALUSec, SrcA, SrcB,
    input  ALU_result, Zero, Overflow, Busy, Done, HI, LO
  );

  modport slave (
    input  Start, ALUSec, SrcA, SrcB,
    output ALU_result, Zero, Overflow, Busy, Done, HI, LO
  );

endinterface

// File: rtl/alu_muldiv_seq_muldiv.sv
// Iterative 1-bit/cycle multiply (shift-add) and restoring divide on operand
// magnitudes; signs are re-applied combinationally while in FIN.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, trial;
  logic               ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign trial    = rem_sh - {1'b0, opnd_q};
  assign ge       = ~trial[WIDTH];
  assign div_next = {(ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          div_d = is_div;
          cnt_d = '0;
          if (is_div) begin
            opnd_d   = b_mag;
            acc_d    = {{WIDTH{1'b0}}, a_mag};
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            state_d  = MD_ITER;
            if (b == '0) begin
              acc_d    = {a, {WIDTH{1'b1}}};
              neg_lo_d = 1'b0;
              neg_hi_d = 1'b0;
              state_d  = MD_FIN;
            end
          end else begin
            opnd_d   = a_mag;
            acc_d    = {{WIDTH{1'b0}}, b_mag};
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = 1'b0;
            state_d  = MD_ITER;
          end
        end
      end
      MD_ITER: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) state_d = MD_FIN;
      end
      MD_FIN:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    prod = neg_lo_q ? -acc_q : acc_q;
    hi   = prod[2*WIDTH-1:WIDTH];
    lo   = prod[WIDTH-1:0];
    if (div_q) begin
      lo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end
  end

  assign busy = (state_q != MD_IDLE);
  assign fin  = (state_q == MD_FIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Registered MIPS execute-stage ALU: single-cycle datapath, HI/LO registers and
// Start/Busy/Done handshake around the iterative mul/div engine.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  alu_muldiv_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             md_busy, md_fin, md_start;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic             accept;
  logic [WIDTH-1:0] alu_res, sum, diff;
  logic             alu_ovf, slt, sltu;
  logic [SHW-1:0]   shamt;

  assign accept   = bus.Start & ~md_busy;
  assign md_start = accept & is_muldiv(bus.ALUSec);

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (md_start),
    .is_div    ((bus.ALUSec == ALU_DIV) || (bus.ALUSec == ALU_DIVU)),
    .is_signed ((bus.ALUSec == ALU_MULT) || (bus.ALUSec == ALU_DIV)),
    .a         (bus.SrcA),
    .b         (bus.SrcB),
    .busy      (md_busy),
    .fin       (md_fin),
    .hi        (md_hi),
    .lo        (md_lo)
  );

  assign sum   = bus.SrcA + bus.SrcB;
  assign diff  = bus.SrcA - bus.SrcB;
  assign slt   = $signed(bus.SrcA) < $signed(bus.SrcB);
  assign sltu  = bus.SrcA < bus.SrcB;
  assign shamt = bus.SrcB[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.ALUSec)
      ALU_AND:  alu_res = bus.SrcA & bus.SrcB;
      ALU_OR:   alu_res = bus.SrcA | bus.SrcB;
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.SrcA[WIDTH-1] == bus.SrcB[WIDTH-1]) && (sum[WIDTH-1] != bus.SrcA[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.SrcA[WIDTH-1] != bus.SrcB[WIDTH-1]) && (diff[WIDTH-1] != bus.SrcA[WIDTH-1]);
      end
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, sltu};
      ALU_XOR:  alu_res = bus.SrcA ^ bus.SrcB;
      ALU_NOR:  alu_res = ~(bus.SrcA | bus.SrcB);
      ALU_SLL:  alu_res = bus.SrcA << shamt;
      ALU_SRL:  alu_res = bus.SrcA >> shamt;
      ALU_SRA:  alu_res = WIDTH'($signed(bus.SrcA) >>> shamt);
      ALU_MFHI: alu_res = hi_q;
      ALU_MFLO: alu_res = lo_q;
      default:  alu_res = '0;
    endcase
  end

  // FIN and a fresh accept are mutually exclusive because Busy covers FIN.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (md_fin) begin
      result_d = md_lo;
      zero_d   = (md_lo == '0);
      ovf_d    = 1'b0;
      done_d   = 1'b1;
      hi_d     = md_hi;
      lo_d     = md_lo;
    end else if (accept && !is_muldiv(bus.ALUSec)) begin
      result_d = alu_res;
      zero_d   = (alu_res == '0);
      ovf_d    = alu_ovf;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.ALU_result = result_q;
  assign bus.Zero       = zero_q;
  assign bus.Overflow   = ovf_q;
  assign bus.Done       = done_q;
  assign bus.Busy       = md_busy;
  assign bus.HI         = hi_q;
  assign bus.LO         = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: hand-computed vectors for single-cycle ops,
// mul/div results and latencies, ignored Starts while Busy, and reset mid-divide.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  alu_muldiv_seq_if #(.WIDTH(W)) bus ();

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request before a rising edge; return #1 after the edge that accepts it.
  task automatic issue(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.ALUSec = op;
    bus.SrcA   = a;
    bus.SrcB   = b;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
  endtask

  // Counts edges with the Start edge as 1; bounded so a stuck engine cannot hang.
  task automatic wait_done(output int n);
    n = 1;
    while (!bus.Done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic alu1(input string tag, input alu_op_t op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp_res,
                      input logic exp_zero, input logic exp_ovf);
    issue(op, a, b);
    check({tag, " done"}, 64'(bus.Done), 64'(1'b1));
    check({tag, " result"}, 64'(bus.ALU_result), 64'(exp_res));
    check({tag, " zero"}, 64'(bus.Zero), 64'(exp_zero));
    check({tag, " ovf"}, 64'(bus.Overflow), 64'(exp_ovf));
  endtask

  task automatic md(input string tag, input alu_op_t op, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                    input logic [W-1:0] exp_lo, input int exp_lat);
    int n;
    issue(op, a, b);
    check({tag, " busy"}, 64'(bus.Busy), 64'(1'b1));
    wait_done(n);
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " hi"}, 64'(bus.HI), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.LO), 64'(exp_lo));
    check({tag, " result"}, 64'(bus.ALU_result), 64'(exp_lo));
  endtask

  initial begin
    int n;
    bus.Start  = 1'b0;
    bus.ALUSec = ALU_AND;
    bus.SrcA   = '0;
    bus.SrcB   = '0;

    #12;
    check("rst result", 64'(bus.ALU_result), 64'h0);
    check("rst zero", 64'(bus.Zero), 64'h0);
    check("rst ovf", 64'(bus.Overflow), 64'h0);
    check("rst busy", 64'(bus.Busy), 64'h0);
    check("rst done", 64'(bus.Done), 64'h0);
    check("rst hi", 64'(bus.HI), 64'h0);
    check("rst lo", 64'(bus.LO), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    alu1("add ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("done drop", 64'(bus.Done), 64'h0);
    check("result hold", 64'(bus.ALU_result), 64'h8000_0000);

    alu1("sub zero", ALU_SUB, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0);
    alu1("sub ovf", ALU_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    alu1("slt", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0);
    alu1("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0);
    alu1("sra", ALU_SRA, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 1'b0);
    alu1("srl", ALU_SRL, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, 1'b0);
    alu1("sll0", ALU_SLL, 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
    alu1("sll amt", ALU_SLL, 32'h1, 32'h23, 32'h8, 1'b0, 1'b0);
    alu1("and", ALU_AND, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0);
    alu1("or", ALU_OR, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 1'b0);
    alu1("xor", ALU_XOR, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, 1'b0);
    alu1("nor", ALU_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    alu1("reserved", alu_op_t'(5'd20), 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b0);

    md("mult", ALU_MULT, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, W + 2);

    // Start held high with a different request and changing operands while Busy.
    issue(ALU_MULTU, 32'hFFFF_FFFE, 32'h3);
    bus.Start  = 1'b1;
    bus.ALUSec = ALU_ADD;
    bus.SrcA   = 32'h1;
    bus.SrcB   = 32'h1;
    wait_done(n);
    bus.Start = 1'b0;
    check("multu latency", 64'(n), 64'(W + 2));
    check("multu hi", 64'(bus.HI), 64'h2);
    check("multu lo", 64'(bus.LO), 64'hFFFF_FFFA);
    check("multu result", 64'(bus.ALU_result), 64'hFFFF_FFFA);
    alu1("mfhi", ALU_MFHI, 32'h0, 32'h0, 32'h2, 1'b0, 1'b0);
    alu1("mflo", ALU_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFA, 1'b0, 1'b0);

    md("div neg", ALU_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, W + 2);
    md("divu by0", ALU_DIVU, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF, 2);
    md("div minneg", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, W + 2);
    md("divu", ALU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, W + 2);
    md("div negb", ALU_DIV, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, W + 2);

    // Abort a divide five cycles in; HI/LO currently hold 1 / 0xFFFFFFFD.
    issue(ALU_DIV, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort busy", 64'(bus.Busy), 64'h0);
    check("abort done", 64'(bus.Done), 64'h0);
    check("abort result", 64'(bus.ALU_result), 64'h0);
    check("abort hi", 64'(bus.HI), 64'h0);
    check("abort lo", 64'(bus.LO), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    alu1("post add", ALU_ADD, 32'h2, 32'h3, 32'h5, 1'b0, 1'b0);
    check("post busy", 64'(bus.Busy), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
